// File: rtl/crf_pkg.sv
// ---------------------------------------------------------------------------
// crf_pkg
// Shared definitions for the CRF tree walker slice:
//   - crfState_e  : walker FSM state encoding
//   - node word field positions (feature select / threshold)
//   - width of the leaf multiply factor actually used by the score datapath
// ---------------------------------------------------------------------------
package crf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      NODE_RD,
      FEAT_RD,
      CMP,
      LEAF_RD,
      LEAF_FEAT,
      CALC,
      DONE
   } crfState_e;

   // Node word layout: [31:24] feature select, [23:0] threshold
   localparam int NODE_FSEL_MSB = 31;
   localparam int NODE_FSEL_LSB = 24;
   localparam int NODE_THR_MSB  = 23;

   // Only the low half of the leaf multiply word takes part in the score
   localparam int LEAF_MULT_W   = 16;

endpackage

// File: rtl/crf_leaf_calc.sv
// ---------------------------------------------------------------------------
// crf_leaf_calc
// Registered multiply-add producing the leaf score:
//   o_score <= low 32 bits of (i_feat * i_mult) + i_offset, modulo 2^32
// The register only loads while i_calcEn is high, so the score stays put
// while the result waits for its consumer.
// Ports:
//   clk, rstN   : clock, synchronous active-low reset
//   i_calcEn    : load enable (walker CALC state)
//   i_feat      : feature value read for the leaf
//   i_mult      : leaf multiply factor (low LEAF_MULT_W bits)
//   i_offset    : leaf offset
//   o_score     : registered score
// ---------------------------------------------------------------------------
module crf_leaf_calc
   import crf_pkg::*;
#(
   parameter int FEAT_W = 24
) (
   input  logic                   clk,
   input  logic                   rstN,
   input  logic                   i_calcEn,
   input  logic [FEAT_W-1:0]      i_feat,
   input  logic [LEAF_MULT_W-1:0] i_mult,
   input  logic [31:0]            i_offset,
   output logic [31:0]            o_score
);

   logic [63:0] w_product;
   logic [31:0] w_sum;
   logic [31:0] r_score;
   logic        w_unused;

   // Full-width product; the score keeps only the low word, so the upper
   // bits drop out and the add wraps naturally at 32 bits.
   assign w_product = 64'(i_feat) * 64'(i_mult);
   assign w_sum     = w_product[31:0] + i_offset;
   assign w_unused  = ^w_product[63:32];

   // Score register, loaded once per tree in CALC and held afterwards
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_score <= '0;
      end else if (i_calcEn) begin
         r_score <= w_sum;
      end
   end

   assign o_score = r_score;

endmodule

// File: rtl/crf_tree_walker.sv
// ---------------------------------------------------------------------------
// crf_tree_walker
// Walks one decision tree from the root to a leaf. Each level takes three
// cycles: read the node word, read the selected feature, compare against the
// threshold and step to the left (feature < threshold) or right child in
// heap order. At the leaf the three leaf words are read, the leaf feature is
// fetched and the score feature*mult+offset is formed in crf_leaf_calc.
// Ports:
//   clk, rstN                     : clock, synchronous active-low reset
//   startValid / startReady       : classify request handshake
//   nodeCellEnable/WriteEnable/Index, nodeData     : node SRAM read port
//   leafCellEnable/WriteEnable/Index,
//   leafFeatureIndex/Multiple/Offset               : leaf SRAM read port
//   featRdEn / featAddr / featData: feature buffer (data one cycle later)
//   resValid / resReady           : result handshake
//   resScore / resLeaf / resPath  : leaf score, leaf reached, branch bits
// ---------------------------------------------------------------------------
module crf_tree_walker
   import crf_pkg::*;
#(
   parameter int STAGES = 5,
   parameter int FEAT_W = 24,
   parameter int FSEL_W = 8
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              startValid,
   output logic              startReady,
   output logic              nodeCellEnable,
   output logic              nodeWriteEnable,
   output logic [STAGES-1:0] nodeIndex,
   input  logic [31:0]       nodeData,
   output logic              leafCellEnable,
   output logic              leafWriteEnable,
   output logic [STAGES-1:0] leafIndex,
   input  logic [31:0]       leafFeatureIndex,
   input  logic [31:0]       leafMultiple,
   input  logic [31:0]       leafOffset,
   output logic              featRdEn,
   output logic [FSEL_W-1:0] featAddr,
   input  logic [FEAT_W-1:0] featData,
   output logic              resValid,
   input  logic              resReady,
   output logic [31:0]       resScore,
   output logic [STAGES-1:0] resLeaf,
   output logic [STAGES-1:0] resPath
);

   localparam int LVL_W = $clog2(STAGES + 1);
   localparam int NODE_FSEL_W = NODE_FSEL_MSB - NODE_FSEL_LSB + 1;
   localparam logic [STAGES:0] FIRST_LEAF = (STAGES+1)'((1 << STAGES) - 1);

   crfState_e                r_state;
   crfState_e                w_nextState;
   logic [STAGES-1:0]        r_nodePtr;
   logic [LVL_W-1:0]         r_level;
   logic [NODE_FSEL_W-1:0]   r_sel;
   logic [FEAT_W-1:0]        r_thr;
   logic [STAGES-1:0]        r_leaf;
   logic [STAGES-1:0]        r_path;
   logic [FSEL_W-1:0]        r_leafFsel;
   logic [LEAF_MULT_W-1:0]   r_leafMult;
   logic [31:0]              r_leafOffset;

   logic                     w_goRight;
   logic [STAGES:0]          w_child;
   logic [STAGES:0]          w_leafFull;
   logic [LVL_W-1:0]         w_levelNext;
   logic                     w_lastLevel;
   logic                     w_calcEn;
   logic                     w_unused;

   // Branch decision and heap-order child: left = 2i+1, right = 2i+2.
   // Equality goes right. The child is one bit wider than a node index
   // because after the last level it points into the leaf range.
   assign w_goRight   = (featData >= r_thr);
   assign w_child     = {r_nodePtr, 1'b0} + {{(STAGES-1){1'b0}}, w_goRight, ~w_goRight};
   assign w_leafFull  = w_child - FIRST_LEAF;
   assign w_levelNext = r_level + LVL_W'(1);
   assign w_lastLevel = (w_levelNext == LVL_W'(STAGES));

   assign w_unused = ^{leafFeatureIndex[31:FSEL_W], leafMultiple[31:LEAF_MULT_W],
                       w_leafFull[STAGES]};

   // The walker only ever reads; the training loader owns SRAM writes
   assign nodeWriteEnable = 1'b0;
   assign leafWriteEnable = 1'b0;

   // State register
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state and Moore outputs. Enables and addresses sit at zero outside
   // their read states so the SRAMs and feature buffer stay idle.
   always_comb begin
      w_nextState    = r_state;
      startReady     = 1'b0;
      nodeCellEnable = 1'b0;
      nodeIndex      = '0;
      leafCellEnable = 1'b0;
      leafIndex      = '0;
      featRdEn       = 1'b0;
      featAddr       = '0;
      resValid       = 1'b0;
      w_calcEn       = 1'b0;
      case (r_state)
         IDLE: begin
            startReady = 1'b1;
            if (startValid) begin
               w_nextState = NODE_RD;
            end
         end
         NODE_RD: begin
            nodeCellEnable = 1'b1;
            nodeIndex      = r_nodePtr;
            w_nextState    = FEAT_RD;
         end
         FEAT_RD: begin
            featRdEn    = 1'b1;
            featAddr    = FSEL_W'(r_sel);
            w_nextState = CMP;
         end
         CMP: begin
            w_nextState = w_lastLevel ? LEAF_RD : NODE_RD;
         end
         LEAF_RD: begin
            leafCellEnable = 1'b1;
            leafIndex      = r_leaf;
            w_nextState    = LEAF_FEAT;
         end
         LEAF_FEAT: begin
            featRdEn    = 1'b1;
            featAddr    = r_leafFsel;
            w_nextState = CALC;
         end
         CALC: begin
            w_calcEn    = 1'b1;
            w_nextState = DONE;
         end
         DONE: begin
            resValid = 1'b1;
            if (resReady) begin
               w_nextState = IDLE;
            end
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   // Traversal datapath: pointer/level/path bookkeeping and capture of the
   // node and leaf words in the cycle their SRAM is enabled. Leaf and path
   // double as the result outputs, so they are cleared on each new request.
   always_ff @(posedge clk) begin
      if (!rstN) begin
         r_nodePtr    <= '0;
         r_level      <= '0;
         r_sel        <= '0;
         r_thr        <= '0;
         r_leaf       <= '0;
         r_path       <= '0;
         r_leafFsel   <= '0;
         r_leafMult   <= '0;
         r_leafOffset <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (startValid) begin
                  r_nodePtr <= '0;
                  r_level   <= '0;
                  r_leaf    <= '0;
                  r_path    <= '0;
               end
            end
            NODE_RD: begin
               r_sel <= nodeData[NODE_FSEL_MSB:NODE_FSEL_LSB];
               r_thr <= FEAT_W'(nodeData[NODE_THR_MSB:0]);
            end
            CMP: begin
               r_level <= w_levelNext;
               r_path  <= r_path | (STAGES'(w_goRight) << r_level);
               if (w_lastLevel) begin
                  r_leaf <= w_leafFull[STAGES-1:0];
               end else begin
                  r_nodePtr <= w_child[STAGES-1:0];
               end
            end
            LEAF_RD: begin
               r_leafFsel   <= leafFeatureIndex[FSEL_W-1:0];
               r_leafMult   <= leafMultiple[LEAF_MULT_W-1:0];
               r_leafOffset <= leafOffset;
            end
            default: begin
            end
         endcase
      end
   end

   crf_leaf_calc #(
      .FEAT_W (FEAT_W)
   ) u_leafCalc (
      .clk      (clk),
      .rstN     (rstN),
      .i_calcEn (w_calcEn),
      .i_feat   (featData),
      .i_mult   (r_leafMult),
      .i_offset (r_leafOffset),
      .o_score  (resScore)
   );

   assign resLeaf = r_leaf;
   assign resPath = r_path;

endmodule

// File: tb/tb_crf_tree_walker.sv
// ---------------------------------------------------------------------------
// tb_crf_tree_walker
// Bench for crf_tree_walker: SRAM and feature buffer models, a job-level
// reference model of the tree walk, a per-cycle compare process, directed
// cases with hand-computed results, and randomized trees.
// ---------------------------------------------------------------------------
module tb_crf_tree_walker;

   localparam int STAGES  = 5;
   localparam int FEAT_W  = 24;
   localparam int FSEL_W  = 8;
   localparam int LATENCY = 3 * STAGES + 3;
   localparam int NLEAF   = 1 << STAGES;

   logic              clk = 1'b0;
   logic              rstN = 1'b0;
   logic              startValid = 1'b0;
   logic              startReady;
   logic              nodeCellEnable;
   logic              nodeWriteEnable;
   logic [STAGES-1:0] nodeIndex;
   logic [31:0]       nodeData;
   logic              leafCellEnable;
   logic              leafWriteEnable;
   logic [STAGES-1:0] leafIndex;
   logic [31:0]       leafFeatureIndex;
   logic [31:0]       leafMultiple;
   logic [31:0]       leafOffset;
   logic              featRdEn;
   logic [FSEL_W-1:0] featAddr;
   logic [FEAT_W-1:0] featData = '0;
   logic              resValid;
   logic              resReady = 1'b0;
   logic [31:0]       resScore;
   logic [STAGES-1:0] resLeaf;
   logic [STAGES-1:0] resPath;

   // Memories seen by the walker
   logic [31:0]       nodeMem [0:NLEAF-1];
   logic [31:0]       leafFiMem [0:NLEAF-1];
   logic [31:0]       leafMulMem [0:NLEAF-1];
   logic [31:0]       leafOffMem [0:NLEAF-1];
   logic [FEAT_W-1:0] featMem [0:255];

   // Bookkeeping
   int nChecks = 0;
   int nFail   = 0;
   int cycleCnt = 0;

   // Reference model state
   int          mPhase = 0;
   int          mEdge = 0;
   bit          mFromReset = 1'b0;
   int          expNodes [STAGES];
   logic [7:0]  expSel [STAGES];
   int          expLeaf = 0;
   logic [STAGES-1:0] expPath = '0;
   logic [31:0] expScore = '0;
   logic [7:0]  expLeafFsel = '0;

   bit expNodeEn, expLeafEn, expFeatEn;
   bit prevResValid = 1'b0;
   int nodeSeq [$];
   int acceptQ [$];
   int riseQ [$];

   logic [31:0]       capScore, capHeldScore;
   logic [STAGES-1:0] capLeaf, capPath;

   crf_tree_walker #(
      .STAGES (STAGES),
      .FEAT_W (FEAT_W),
      .FSEL_W (FSEL_W)
   ) dut (
      .clk              (clk),
      .rstN             (rstN),
      .startValid       (startValid),
      .startReady       (startReady),
      .nodeCellEnable   (nodeCellEnable),
      .nodeWriteEnable  (nodeWriteEnable),
      .nodeIndex        (nodeIndex),
      .nodeData         (nodeData),
      .leafCellEnable   (leafCellEnable),
      .leafWriteEnable  (leafWriteEnable),
      .leafIndex        (leafIndex),
      .leafFeatureIndex (leafFeatureIndex),
      .leafMultiple     (leafMultiple),
      .leafOffset       (leafOffset),
      .featRdEn         (featRdEn),
      .featAddr         (featAddr),
      .featData         (featData),
      .resValid         (resValid),
      .resReady         (resReady),
      .resScore         (resScore),
      .resLeaf          (resLeaf),
      .resPath          (resPath)
   );

   always #5 clk = ~clk;

   // SRAMs answer in the same cycle their cell is enabled; otherwise the
   // outputs carry junk the walker must ignore.
   assign nodeData         = nodeCellEnable ? nodeMem[nodeIndex]    : 32'hDEADBEEF;
   assign leafFeatureIndex = leafCellEnable ? leafFiMem[leafIndex]  : 32'hBADC0FFE;
   assign leafMultiple     = leafCellEnable ? leafMulMem[leafIndex] : 32'hBADC0FFE;
   assign leafOffset       = leafCellEnable ? leafOffMem[leafIndex] : 32'hBADC0FFE;

   // Feature buffer returns data one cycle after the read strobe
   always @(posedge clk) begin
      featData <= featRdEn ? featMem[featAddr] : 24'h5A5A5A;
   end

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] required);
      nChecks++;
      if (actual !== required) begin
         nFail++;
         $display("[TB] FAIL %s actual=%0h required=%0h at cycle %0d",
                  name, actual, required, cycleCnt);
      end
   endtask

   // Walk the tree straight from the memories
   function automatic void modelCompute();
      int          idx;
      logic [7:0]  s;
      logic [23:0] t;
      bit          right;
      logic [63:0] acc;
      idx = 0;
      for (int lvl = 0; lvl < STAGES; lvl++) begin
         s = nodeMem[idx][31:24];
         t = nodeMem[idx][23:0];
         expNodes[lvl] = idx;
         expSel[lvl]   = s;
         right = (featMem[s] >= t);
         expPath[lvl] = right;
         idx = 2 * idx + (right ? 2 : 1);
      end
      expLeaf     = idx - (NLEAF - 1);
      expLeafFsel = leafFiMem[expLeaf][7:0];
      acc = 64'(featMem[expLeafFsel]) * 64'(leafMulMem[expLeaf][15:0])
          + 64'(leafOffMem[expLeaf]);
      expScore = acc[31:0];
   endfunction

   // Job-level timing model: idle, busy for LATENCY edges, done until taken
   always @(posedge clk) begin
      cycleCnt++;
      if (!rstN) begin
         mPhase     = 0;
         mEdge      = 0;
         mFromReset = 1'b1;
      end else begin
         case (mPhase)
            0: begin
               if (startValid) begin
                  mPhase     = 1;
                  mEdge      = 0;
                  mFromReset = 1'b0;
                  modelCompute();
               end
            end
            1: begin
               mEdge++;
               if (mEdge == LATENCY) mPhase = 2;
            end
            default: begin
               if (resReady) mPhase = 0;
            end
         endcase
      end
   end

   // Per-cycle compare against the model, plus event recording
   always @(negedge clk) begin
      checkOutput("nodeWriteEnable", nodeWriteEnable, 0);
      checkOutput("leafWriteEnable", leafWriteEnable, 0);
      checkOutput("cellOverlap", nodeCellEnable & leafCellEnable, 0);
      checkOutput("startReady", startReady, mPhase == 0);
      checkOutput("resValid", resValid, mPhase == 2);
      expNodeEn = 1'b0;
      expLeafEn = 1'b0;
      expFeatEn = 1'b0;
      if (mPhase == 1) begin
         expNodeEn = (mEdge < 3 * STAGES) && (mEdge % 3 == 0);
         expFeatEn = ((mEdge < 3 * STAGES) && (mEdge % 3 == 1)) || (mEdge == 3 * STAGES + 1);
         expLeafEn = (mEdge == 3 * STAGES);
      end
      checkOutput("nodeCellEnable", nodeCellEnable, expNodeEn);
      checkOutput("leafCellEnable", leafCellEnable, expLeafEn);
      checkOutput("featRdEn", featRdEn, expFeatEn);
      if (expNodeEn) checkOutput("nodeIndex", nodeIndex, expNodes[mEdge / 3]);
      if (expLeafEn) checkOutput("leafIndex", leafIndex, expLeaf);
      if (expFeatEn) begin
         checkOutput("featAddr", featAddr,
                     (mEdge == 3 * STAGES + 1) ? expLeafFsel : expSel[mEdge / 3]);
      end
      if (mPhase == 2) begin
         checkOutput("resScore", resScore, expScore);
         checkOutput("resLeaf", resLeaf, expLeaf);
         checkOutput("resPath", resPath, expPath);
      end
      if (mPhase == 0 && mFromReset) begin
         checkOutput("rstScore", resScore, 0);
         checkOutput("rstLeaf", resLeaf, 0);
         checkOutput("rstPath", resPath, 0);
         checkOutput("rstNodeIndex", nodeIndex, 0);
         checkOutput("rstLeafIndex", leafIndex, 0);
         checkOutput("rstFeatAddr", featAddr, 0);
      end
      if (nodeCellEnable) nodeSeq.push_back(int'(nodeIndex));
      if (startValid && startReady) acceptQ.push_back(cycleCnt + 1);
      if (resValid && !prevResValid) riseQ.push_back(cycleCnt);
      prevResValid = resValid;
   end

   task automatic fillMem(input logic [23:0] thr, input logic [23:0] feat,
                          input logic [31:0] mult, input logic [31:0] offs);
      for (int i = 0; i < NLEAF; i++) begin
         nodeMem[i]    = {8'(i * 7), thr};
         leafFiMem[i]  = 32'(i);
         leafMulMem[i] = mult;
         leafOffMem[i] = offs;
      end
      for (int i = 0; i < 256; i++) featMem[i] = feat;
   endtask

   task automatic randomizeMem();
      logic [7:0]  s;
      logic [23:0] f;
      for (int i = 0; i < 256; i++) featMem[i] = 24'($urandom);
      for (int i = 0; i < NLEAF; i++) begin
         s = 8'($urandom_range(0, 255));
         f = featMem[s];
         case ($urandom_range(0, 3))
            0:       nodeMem[i] = {s, f};
            1:       nodeMem[i] = {s, f + 24'd1};
            2:       nodeMem[i] = {s, f - 24'd1};
            default: nodeMem[i] = {s, 24'($urandom)};
         endcase
         leafFiMem[i]  = $urandom;
         leafMulMem[i] = $urandom;
         leafOffMem[i] = $urandom;
      end
   endtask

   // One classification: start, wait (bounded) for the result, optionally
   // stall the consumer, then take the result.
   task automatic applyStimulus(input int holdCycles);
      bit got;
      nodeSeq.delete();
      acceptQ.delete();
      riseQ.delete();
      @(posedge clk); #1 startValid = 1'b1;
      @(posedge clk); #1 startValid = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 4 * LATENCY && !got; i++) begin
         @(negedge clk);
         if (resValid) got = 1'b1;
      end
      if (!got) checkOutput("resValidTimeout", resValid, 1);
      capScore = resScore;
      capLeaf  = resLeaf;
      capPath  = resPath;
      repeat (holdCycles) @(negedge clk);
      capHeldScore = resScore;
      @(posedge clk); #1 resReady = 1'b1;
      @(posedge clk); #1 resReady = 1'b0;
   endtask

   task automatic checkLatency(input string name);
      if (acceptQ.size() >= 1 && riseQ.size() >= 1)
         checkOutput(name, riseQ[0] - acceptQ[0], LATENCY);
      else
         checkOutput({name, "Events"}, riseQ.size(), 1);
   endtask

   initial begin
      int exp1 [5];
      int exp2 [5];
      int rises;
      bit seenPrev;
      exp1 = '{0, 1, 3, 7, 15};
      exp2 = '{0, 2, 6, 14, 30};

      fillMem(24'hFFFFFF, 24'h10, 32'd3, 32'd5);
      rstN = 1'b0;
      repeat (3) @(posedge clk);
      #1 rstN = 1'b1;
      @(negedge clk);
      checkOutput("resetStartReady", startReady, 1);
      checkOutput("resetResValid", resValid, 0);

      // All-left walk
      applyStimulus(0);
      checkOutput("leftModelScore", expScore, 32'h35);
      checkOutput("leftScore", capScore, 32'h35);
      checkOutput("leftLeaf", capLeaf, 0);
      checkOutput("leftPath", capPath, 5'b00000);
      checkLatency("leftLatency");
      checkOutput("leftNodeCount", nodeSeq.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < nodeSeq.size()) checkOutput("leftNodeSeq", nodeSeq[i], exp1[i]);

      // All-right walk
      fillMem(24'h000000, 24'h10, 32'd3, 32'd5);
      applyStimulus(0);
      checkOutput("rightModelLeaf", expLeaf, 31);
      checkOutput("rightLeaf", capLeaf, 31);
      checkOutput("rightPath", capPath, 5'b11111);
      checkOutput("rightNodeCount", nodeSeq.size(), 5);
      for (int i = 0; i < 5; i++)
         if (i < nodeSeq.size()) checkOutput("rightNodeSeq", nodeSeq[i], exp2[i]);

      // Equality branches right
      fillMem(24'h000100, 24'h000100, 32'd3, 32'd5);
      applyStimulus(0);
      checkOutput("equalLeaf", capLeaf, 31);
      checkOutput("equalPath", capPath, 5'b11111);

      // Consumer stall in DONE
      fillMem(24'hFFFFFF, 24'h10, 32'd3, 32'd5);
      applyStimulus(10);
      checkOutput("heldScore", capHeldScore, 32'h35);
      @(negedge clk);
      checkOutput("idleAfterAccept", startReady, 1);

      // Score wrap corner
      fillMem(24'h123456, 24'hFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF);
      applyStimulus(0);
      checkOutput("wrapModelScore", expScore, 32'hFEFF0000);
      checkOutput("wrapScore", capScore, 32'hFEFF0000);

      // Reset during CMP of level 2 (eighth cycle after acceptance)
      fillMem(24'h000000, 24'h10, 32'd3, 32'd5);
      @(posedge clk); #1 startValid = 1'b1;
      @(posedge clk); #1 startValid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rstN = 1'b0;
      @(posedge clk); #1 rstN = 1'b1;
      @(negedge clk);
      checkOutput("midRstStartReady", startReady, 1);
      checkOutput("midRstResValid", resValid, 0);
      checkOutput("midRstPath", resPath, 0);
      checkOutput("midRstScore", resScore, 0);
      checkOutput("midRstNodeEn", nodeCellEnable, 0);
      applyStimulus(0);
      checkLatency("afterRstLatency");
      checkOutput("afterRstLeaf", capLeaf, 31);

      // Back-to-back with startValid and resReady held high
      fillMem(24'hFFFFFF, 24'h10, 32'd3, 32'd5);
      acceptQ.delete();
      riseQ.delete();
      @(posedge clk); #1 startValid = 1'b1; resReady = 1'b1;
      rises = 0;
      seenPrev = 1'b0;
      for (int i = 0; i < 8 * LATENCY && rises < 2; i++) begin
         @(negedge clk);
         if (resValid && !seenPrev) rises++;
         seenPrev = resValid;
      end
      if (rises < 2) checkOutput("b2bTimeout", rises, 2);
      @(posedge clk); #1 startValid = 1'b0; resReady = 1'b0;
      checkOutput("b2bAcceptCount", acceptQ.size(), 2);
      if (acceptQ.size() >= 2 && riseQ.size() >= 2) begin
         checkOutput("b2bLatency0", riseQ[0] - acceptQ[0], LATENCY);
         checkOutput("b2bGap", acceptQ[1] - riseQ[0], 2);
         checkOutput("b2bLatency1", riseQ[1] - acceptQ[1], LATENCY);
      end

      // Randomized trees
      for (int j = 0; j < 40; j++) begin
         randomizeMem();
         repeat ($urandom_range(0, 3)) @(posedge clk);
         applyStimulus($urandom_range(0, 3));
      end
      repeat (3) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
